// File: rtl/dsi_rx_pkg.sv
// Shared types and constants for the DSI lane receiver: FSM states, sync byte, LP line codes.
package dsi_rx_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HS_RQST   = 3'd1,
        HS_PREP   = 3'd2,
        HS_SYNC   = 3'd3,
        HS_ACTIVE = 3'd4,
        WAIT_STOP = 3'd5
    } state_e;

    localparam logic [7:0] DSI_SYNC_BYTE = 8'hB8;

    // LP pair codes, ordered {Dp, Dn}
    localparam logic [1:0] LP_11 = 2'b11;
    localparam logic [1:0] LP_10 = 2'b10;
    localparam logic [1:0] LP_01 = 2'b01;
    localparam logic [1:0] LP_00 = 2'b00;

endpackage

// File: rtl/dsi_lp_filter.sv
// LP pair conditioning: 2-flop synchronizer followed by a deglitcher that accepts a new
// {Dp,Dn} value only after LP_FILTER consecutive equal synchronized samples.
module dsi_lp_filter
    import dsi_rx_pkg::*;
#(
    parameter int LP_FILTER = 4
) (
    input  logic       clk_sys,
    input  logic       rst,
    input  logic [1:0] lp_raw_i,
    output logic [1:0] lp_f_o
);

    logic [1:0] sync1_q, sync2_q;
    logic [1:0] cand_q, lp_f_q;
    logic [3:0] cnt_q;
    logic [3:0] run_len;

    // Length of the current run of identical samples that differ from the accepted value
    always_comb begin
        if ((sync2_q == cand_q) && (sync2_q != lp_f_q)) begin
            run_len = cnt_q + 4'd1;
        end else begin
            run_len = 4'd1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            sync1_q <= LP_11;
            sync2_q <= LP_11;
            cand_q  <= LP_11;
            lp_f_q  <= LP_11;
            cnt_q   <= 4'd0;
        end else begin
            sync1_q <= lp_raw_i;
            sync2_q <= sync1_q;
            cand_q  <= sync2_q;
            if (sync2_q == lp_f_q) begin
                cnt_q <= 4'd0;
            end else if (run_len >= 4'(LP_FILTER)) begin
                lp_f_q <= sync2_q;
                cnt_q  <= 4'd0;
            end else begin
                cnt_q <= run_len;
            end
        end
    end

    assign lp_f_o = lp_f_q;

endmodule

// File: rtl/dsi_lane_rx.sv
// DSI D-PHY data lane receiver: LP sequence tracking, HS sync hunt and payload delivery.
// Define DSI_LANE_RX_ALIGN_EN to hunt the sync byte at any of 8 bit offsets.
module dsi_lane_rx
    import dsi_rx_pkg::*;
#(
    parameter int LP_FILTER    = 4,
    parameter int T_LPX_MIN    = 25,
    parameter int T_HS_SETTLE  = 20,
    parameter int SYNC_TIMEOUT = 64
) (
    input  logic       clk_sys,
    input  logic       rst,
    input  logic       LP_p_input,
    input  logic       LP_n_input,
    input  logic [7:0] hs_data,
    input  logic       hs_valid,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_sot,
    output logic       out_eot,
    output logic       active,
    output logic       err_sot,
    output logic       err_ctrl,
    output state_e     dbg_state_o
);

    localparam logic [7:0] RQST_MAX     = 8'(T_LPX_MIN);
    localparam logic [7:0] SETTLE_LAST  = 8'(T_HS_SETTLE - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(SYNC_TIMEOUT - 1);

    logic [1:0] lp_f;

    dsi_lp_filter #(
        .LP_FILTER(LP_FILTER)
    ) u_lp_filter (
        .clk_sys (clk_sys),
        .rst     (rst),
        .lp_raw_i({LP_p_input, LP_n_input}),
        .lp_f_o  (lp_f)
    );

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       first_q, first_d;
    logic [7:0] out_data_q, out_data_d;
    logic       out_valid_q, out_valid_d;
    logic       out_sot_q, out_sot_d;
    logic       out_eot_q, out_eot_d;
    logic       err_sot_q, err_sot_d;
    logic       err_ctrl_q, err_ctrl_d;

    logic       sync_hit;
    logic [7:0] aligned_byte;

`ifdef DSI_LANE_RX_ALIGN_EN
    logic [7:0]  prev_q;
    logic [2:0]  off_q;
    logic [2:0]  sync_off;
    logic [15:0] window;

    assign window = {hs_data, prev_q};

    // Descending scan so the lowest matching offset is the one that sticks
    always_comb begin
        sync_hit = 1'b0;
        sync_off = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (window[k +: 8] == DSI_SYNC_BYTE) begin
                sync_hit = 1'b1;
                sync_off = 3'(k);
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            prev_q <= 8'd0;
            off_q  <= 3'd0;
        end else begin
            if (hs_valid) begin
                prev_q <= hs_data;
            end
            if ((state_q == HS_SYNC) && hs_valid && sync_hit) begin
                off_q <= sync_off;
            end
        end
    end

    assign aligned_byte = window[off_q +: 8];
`else
    assign sync_hit     = (hs_data == DSI_SYNC_BYTE);
    assign aligned_byte = hs_data;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        first_d     = first_q;
        out_data_d  = 8'd0;
        out_valid_d = 1'b0;
        out_sot_d   = 1'b0;
        out_eot_d   = 1'b0;
        err_sot_d   = 1'b0;
        err_ctrl_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (lp_f == LP_01) begin
                    state_d = HS_RQST;
                    cnt_d   = 8'd0;
                end
            end
            HS_RQST: begin
                unique case (lp_f)
                    LP_00: begin
                        if (cnt_q == RQST_MAX) begin
                            state_d = HS_PREP;
                            cnt_d   = 8'd0;
                        end else begin
                            err_ctrl_d = 1'b1;
                            state_d    = WAIT_STOP;
                        end
                    end
                    LP_11: state_d = IDLE;
                    LP_10: begin
                        err_ctrl_d = 1'b1;
                        state_d    = WAIT_STOP;
                    end
                    default: begin
                        if (cnt_q != RQST_MAX) begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end
                endcase
            end
            HS_PREP: begin
                if (lp_f == LP_11) begin
                    err_sot_d = 1'b1;
                    state_d   = IDLE;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = HS_SYNC;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            HS_SYNC: begin
                if (lp_f == LP_11) begin
                    err_sot_d = 1'b1;
                    state_d   = IDLE;
                end else if (hs_valid) begin
                    if (sync_hit) begin
                        state_d = HS_ACTIVE;
                        first_d = 1'b1;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        err_sot_d = 1'b1;
                        state_d   = WAIT_STOP;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            HS_ACTIVE: begin
                // A byte arriving on the stop-state transition cycle is dropped
                if (lp_f == LP_11) begin
                    out_eot_d = 1'b1;
                    state_d   = IDLE;
                end else if ((lp_f == LP_01) || (lp_f == LP_10)) begin
                    err_ctrl_d = 1'b1;
                    state_d    = WAIT_STOP;
                end else if (hs_valid) begin
                    out_valid_d = 1'b1;
                    out_data_d  = aligned_byte;
                    out_sot_d   = first_q;
                    first_d     = 1'b0;
                end
            end
            WAIT_STOP: begin
                if (lp_f == LP_11) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            first_q     <= 1'b0;
            out_data_q  <= 8'd0;
            out_valid_q <= 1'b0;
            out_sot_q   <= 1'b0;
            out_eot_q   <= 1'b0;
            err_sot_q   <= 1'b0;
            err_ctrl_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            first_q     <= first_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_sot_q   <= out_sot_d;
            out_eot_q   <= out_eot_d;
            err_sot_q   <= err_sot_d;
            err_ctrl_q  <= err_ctrl_d;
        end
    end

    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign out_sot     = out_sot_q;
    assign out_eot     = out_eot_q;
    assign err_sot     = err_sot_q;
    assign err_ctrl    = err_ctrl_q;
    assign active      = (state_q == HS_SYNC) || (state_q == HS_ACTIVE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dsi_lane_rx.sv
// Bench for dsi_lane_rx: directed LP-sequence cases plus randomized bursts scored against
// a bit-stream reference model (honours DSI_LANE_RX_ALIGN_EN).
module tb_dsi_lane_rx;
    import dsi_rx_pkg::*;

    localparam int SYNC_TIMEOUT = 64;

    // ---------------- clock / reset ----------------
    logic       clk_sys = 1'b0;
    logic       rst;
    logic       lp_p, lp_n;
    logic [7:0] hs_data;
    logic       hs_valid;
    logic [7:0] out_data;
    logic       out_valid, out_sot, out_eot, active, err_sot, err_ctrl;
    state_e     dbg_state;

    always #5 clk_sys = ~clk_sys;

    dsi_lane_rx dut (
        .clk_sys    (clk_sys),
        .rst        (rst),
        .LP_p_input (lp_p),
        .LP_n_input (lp_n),
        .hs_data    (hs_data),
        .hs_valid   (hs_valid),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_sot    (out_sot),
        .out_eot    (out_eot),
        .active     (active),
        .err_sot    (err_sot),
        .err_ctrl   (err_ctrl),
        .dbg_state_o(dbg_state)
    );

    // ---------------- scoreboard ----------------
    int         n_checks = 0;
    int         n_errors = 0;
    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];
    logic [7:0] burst_q[$];
    logic [7:0] prev_model = 8'd0;
    int         eot_cnt = 0, err_sot_cnt = 0, err_ctrl_cnt = 0;
    int         exp_eot, exp_err_sot;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk_sys) begin
        if (out_valid) got_q.push_back({out_sot, out_data});
        if (out_eot) begin
            eot_cnt++;
            check_eq("eot_without_valid", 32'(out_valid), 32'd0);
        end
        if (err_sot) err_sot_cnt++;
        if (err_ctrl) err_ctrl_cnt++;
    end

    // Reference: sync is a B8 found at some bit position of the 16-bit {current, previous}
    // byte window (positions 0..7 when aligning, only the current byte otherwise).
    function automatic void model_burst();
        logic [7:0]  prev;
        logic [15:0] win;
        logic        found, dead, first;
        int          off, beats, lo, hi;
`ifdef DSI_LANE_RX_ALIGN_EN
        lo = 0; hi = 7;
`else
        lo = 8; hi = 8;
`endif
        prev = prev_model; found = 1'b0; dead = 1'b0; first = 1'b1; off = 0; beats = 0;
        exp_q.delete(); exp_eot = 0; exp_err_sot = 0;
        foreach (burst_q[i]) begin
            win = {burst_q[i], prev};
            if (!dead && found) begin
                exp_q.push_back({first, win[off +: 8]});
                first = 1'b0;
            end else if (!dead) begin
                for (int k = lo; k <= hi && !found; k++) begin
                    if (win[k +: 8] == 8'hB8) begin
                        found = 1'b1;
                        off   = k;
                    end
                end
                if (!found) begin
                    beats++;
                    if (beats == SYNC_TIMEOUT) dead = 1'b1;
                end
            end
            prev = burst_q[i];
        end
        if (dead) exp_err_sot = 1;
        else if (found) exp_eot = 1;
        else exp_err_sot = 1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic hold_lp(input logic [1:0] v, input int n);
        lp_p = v[1];
        lp_n = v[0];
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic send_beat(input logic [7:0] d);
        hs_valid = 1'b1;
        hs_data  = d;
        prev_model = d;
        @(negedge clk_sys);
        hs_valid = 1'b0;
        hs_data  = 8'd0;
    endtask

    task automatic clear_obs();
        got_q.delete();
        eot_cnt = 0; err_sot_cnt = 0; err_ctrl_cnt = 0;
    endtask

    task automatic start_burst();
        model_burst();
        clear_obs();
        hold_lp(LP_01, 40);
        hold_lp(LP_00, 40);
        foreach (burst_q[i]) send_beat(burst_q[i]);
        repeat (2) @(negedge clk_sys);
    endtask

    task automatic end_burst(input string tag);
        hold_lp(LP_11, 15);
        check_eq({tag, ".n_bytes"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check_eq($sformatf("%s.byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        check_eq({tag, ".eot"}, 32'(eot_cnt), 32'(exp_eot));
        check_eq({tag, ".err_sot"}, 32'(err_sot_cnt), 32'(exp_err_sot));
        check_eq({tag, ".err_ctrl"}, 32'(err_ctrl_cnt), 32'd0);
        check_eq({tag, ".state"}, 32'(dbg_state), 32'(IDLE));
    endtask

    task automatic push_bits(inout bit bits[$], input logic [7:0] b);
        for (int j = 0; j < 8; j++) bits.push_back(b[j]);
    endtask

    task automatic build_random_burst();
        bit         bits[$];
        logic [7:0] b;
        int         lead, shift, npay;
        burst_q.delete();
        lead = $urandom_range(0, 3);
        npay = $urandom_range(2, 10);
`ifdef DSI_LANE_RX_ALIGN_EN
        shift = $urandom_range(0, 7);
`else
        shift = 0;
`endif
        repeat (lead * 8 + shift) bits.push_back(bit'($urandom_range(0, 1)));
        push_bits(bits, 8'hB8);
        repeat (npay) push_bits(bits, 8'($urandom_range(0, 255)));
        push_bits(bits, 8'h00);
        while (bits.size() > 0) begin
            b = 8'd0;
            for (int j = 0; j < 8; j++) if (bits.size() > 0) b[j] = bits.pop_front();
            burst_q.push_back(b);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit saw_non_idle;
        rst = 1'b1; lp_p = 1'b1; lp_n = 1'b1; hs_valid = 1'b0; hs_data = 8'd0;
        repeat (3) @(negedge clk_sys);
        check_eq("rst.out_valid", 32'(out_valid), 0);
        check_eq("rst.out_data", 32'(out_data), 0);
        check_eq("rst.flags", 32'({out_sot, out_eot, active, err_sot, err_ctrl}), 0);
        check_eq("rst.state", 32'(dbg_state), 32'(IDLE));
        rst = 1'b0;
        hold_lp(LP_11, 10);

        // Basic burst: sync then 11,22,33 and a trailer byte
        send_beat(8'h00);
        burst_q = '{8'hB8, 8'h11, 8'h22, 8'h33, 8'h00};
        start_burst();
        check_eq("t1.active", 32'(active), 1);
        end_burst("t1");
        check_eq("t1.first", 32'(got_q.size() > 0 ? got_q[0] : 9'h1FF), 32'h111);
        check_eq("t1.second", 32'(got_q.size() > 1 ? got_q[1] : 9'h1FF), 32'h022);
        check_eq("t1.third", 32'(got_q.size() > 2 ? got_q[2] : 9'h1FF), 32'h033);

        // Short LP-01 before LP-00
        clear_obs();
        hold_lp(LP_01, 10);
        hold_lp(LP_00, 20);
        check_eq("t2.state_wait", 32'(dbg_state), 32'(WAIT_STOP));
        send_beat(8'hB8);
        send_beat(8'h11);
        repeat (2) @(negedge clk_sys);
        hold_lp(LP_11, 15);
        check_eq("t2.no_output", 32'(got_q.size()), 0);
        check_eq("t2.err_ctrl", 32'(err_ctrl_cnt), 1);
        check_eq("t2.other_pulses", 32'(err_sot_cnt + eot_cnt), 0);
        check_eq("t2.state_idle", 32'(dbg_state), 32'(IDLE));

        // Sync never found
        send_beat(8'h00);
        burst_q.delete();
        repeat (SYNC_TIMEOUT) burst_q.push_back(8'h00);
        start_burst();
        check_eq("t3.state_wait", 32'(dbg_state), 32'(WAIT_STOP));
        check_eq("t3.err_sot_now", 32'(err_sot_cnt), 1);
        end_burst("t3");

        // {B8,5A} delayed by 3 bits
        send_beat(8'h00);
        burst_q = '{8'hC0, 8'hD5, 8'h02};
        repeat (61) burst_q.push_back(8'h00);
        start_burst();
        end_burst("t4");
`ifdef DSI_LANE_RX_ALIGN_EN
        check_eq("t4.first", 32'(got_q.size() > 0 ? got_q[0] : 9'h1FF), 32'h15A);
`else
        check_eq("t4.err_sot", 32'(err_sot_cnt), 1);
`endif

        // 2-cycle LP-01 glitch in IDLE
        clear_obs();
        saw_non_idle = 1'b0;
        lp_p = 1'b0; lp_n = 1'b1;
        repeat (2) @(negedge clk_sys);
        lp_p = 1'b1; lp_n = 1'b1;
        repeat (20) begin
            @(negedge clk_sys);
            if (dbg_state != IDLE) saw_non_idle = 1'b1;
        end
        check_eq("t5.stayed_idle", 32'(saw_non_idle), 0);
        check_eq("t5.pulses", 32'(err_sot_cnt + err_ctrl_cnt + eot_cnt), 0);

        // Aborted request and LP-10 during request
        clear_obs();
        hold_lp(LP_01, 40);
        hold_lp(LP_11, 15);
        check_eq("t7.abort_pulses", 32'(err_sot_cnt + err_ctrl_cnt + eot_cnt), 0);
        check_eq("t7.abort_state", 32'(dbg_state), 32'(IDLE));
        hold_lp(LP_01, 40);
        hold_lp(LP_10, 15);
        check_eq("t7.lp10_state", 32'(dbg_state), 32'(WAIT_STOP));
        hold_lp(LP_11, 15);
        check_eq("t7.lp10_err_ctrl", 32'(err_ctrl_cnt), 1);
        check_eq("t7.lp10_state_idle", 32'(dbg_state), 32'(IDLE));

        // Randomized bursts, prev byte carried across bursts
        for (int r = 0; r < 8; r++) begin
            build_random_burst();
            start_burst();
            end_burst($sformatf("rnd%0d", r));
        end

        // Reset in the middle of HS_ACTIVE after 5 output bytes
        send_beat(8'h00);
        burst_q = '{8'hB8};
`ifdef DSI_LANE_RX_ALIGN_EN
        repeat (6) burst_q.push_back(8'($urandom_range(0, 255)));
`else
        repeat (5) burst_q.push_back(8'($urandom_range(0, 255)));
`endif
        model_burst();
        clear_obs();
        hold_lp(LP_01, 40);
        hold_lp(LP_00, 40);
        foreach (burst_q[i]) send_beat(burst_q[i]);
        rst = 1'b1;
        @(negedge clk_sys);
        check_eq("t6.out_valid", 32'(out_valid), 0);
        check_eq("t6.out_data", 32'(out_data), 0);
        check_eq("t6.flags", 32'({out_sot, out_eot, active, err_sot, err_ctrl}), 0);
        check_eq("t6.state", 32'(dbg_state), 32'(IDLE));
        rst = 1'b0;
        prev_model = 8'd0;
        check_eq("t6.n_bytes", 32'(got_q.size()), 5);
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check_eq($sformatf("t6.byte%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
        hold_lp(LP_00, 10);
        hold_lp(LP_11, 15);
        check_eq("t6.no_eot", 32'(eot_cnt), 0);
        check_eq("t6.no_err", 32'(err_sot_cnt + err_ctrl_cnt), 0);

        // Receiver still works after the reset
        build_random_burst();
        start_burst();
        end_burst("post_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
